// File: rtl/fir_sweep_sequencer.sv
// Frequency-response sweep sequencer for the pipelined FIR filter.
// Per test point: enable stimulus, wait for settling, peak-hold signed y over a window, report.
module fir_sweep_sequencer #(
    parameter int OUT_WIDTH     = 40,
    parameter int N_TAPS        = 32,
    parameter int SETTLE_CYCLES = 3 * N_TAPS / 2,
    parameter int NUM_TESTS     = 14,
    parameter int WIN_WIDTH     = 16,
    parameter int DC_WIN        = 10
) (
    input  logic                                                   clk,
    input  logic                                                   rst_n,
    input  logic                                                   start,
    input  logic                                                   abort,
    input  logic [WIN_WIDTH-1:0]                                   win_len,
    input  logic [OUT_WIDTH-1:0]                                   y,
    output logic [((NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1)-1:0]   test_idx,
    output logic                                                   drive_en,
    output logic                                                   result_valid,
    output logic [OUT_WIDTH-1:0]                                   result_peak,
    output logic [((NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1)-1:0]   result_idx,
    output logic                                                   busy,
    output logic                                                   done
);

    localparam int IDX_W = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1;
    localparam int SET_W = $clog2(SETTLE_CYCLES) + 1;
    localparam int CNT_W = (WIN_WIDTH > SET_W) ? WIN_WIDTH : SET_W;

    localparam logic [CNT_W-1:0]     SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]     GAP_LAST    = CNT_W'(1);
    localparam logic [IDX_W-1:0]     LAST_IDX    = IDX_W'(NUM_TESTS - 1);
    localparam logic [WIN_WIDTH-1:0] DC_LAST     = WIN_WIDTH'(DC_WIN - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEASURE,
        ST_REPORT,
        ST_GAP
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [WIN_WIDTH-1:0] win_last;
    logic [OUT_WIDTH-1:0] peak;
    logic [OUT_WIDTH-1:0] peak_next;

    always_comb begin
        peak_next = peak;
        if ($signed(y) > $signed(peak)) begin
            peak_next = y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            win_last     <= '0;
            peak         <= '0;
            test_idx     <= '0;
            drive_en     <= 1'b0;
            result_valid <= 1'b0;
            result_peak  <= '0;
            result_idx   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else if (state != ST_IDLE && abort) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            test_idx     <= '0;
            drive_en     <= 1'b0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            done         <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state    <= ST_SETTLE;
                        test_idx <= '0;
                        drive_en <= 1'b1;
                        busy     <= 1'b1;
                        cnt      <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        // this edge's y is the first sample of the window
                        peak     <= y;
                        win_last <= (win_len == '0) ? DC_LAST : win_len - 1'b1;
                        cnt      <= '0;
                        state    <= ST_MEASURE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_MEASURE: begin
                    peak <= peak_next;
                    if (cnt == CNT_W'(win_last)) begin
                        state        <= ST_REPORT;
                        cnt          <= '0;
                        result_valid <= 1'b1;
                        result_peak  <= peak_next;
                        result_idx   <= test_idx;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_REPORT: begin
                    drive_en <= 1'b0;
                    cnt      <= '0;
                    state    <= ST_GAP;
                end
                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt <= '0;
                        if (test_idx == LAST_IDX) begin
                            state    <= ST_IDLE;
                            test_idx <= '0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            state    <= ST_SETTLE;
                            test_idx <= test_idx + 1'b1;
                            drive_en <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_sweep_sequencer.sv
// Bench for fir_sweep_sequencer: offset-based sweep model checked every cycle,
// plus literal expectations on result timing, peaks and reset behaviour.
module tb_fir_sweep_sequencer;

    localparam int OW  = 40;
    localparam int WW  = 16;
    localparam int S   = 6;
    localparam int N   = 3;
    localparam int DCW = 10;
    localparam int IW  = 2;
    localparam logic signed [OW-1:0] MAXP = {1'b0, {(OW-1){1'b1}}};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [WW-1:0] win_len = 16'd4;
    logic signed [OW-1:0] y = '0;

    logic [IW-1:0] test_idx;
    logic          drive_en;
    logic          result_valid;
    logic [OW-1:0] result_peak;
    logic [IW-1:0] result_idx;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    fir_sweep_sequencer #(
        .OUT_WIDTH(OW), .N_TAPS(4), .SETTLE_CYCLES(S), .NUM_TESTS(N),
        .WIN_WIDTH(WW), .DC_WIN(DCW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .win_len(win_len), .y(y), .test_idx(test_idx), .drive_en(drive_en),
        .result_valid(result_valid), .result_peak(result_peak),
        .result_idx(result_idx), .busy(busy), .done(done)
    );

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: each test is an offset o from its start; samples at offsets S..S+W form the window.
    bit                   m_active = 1'b0;
    int                   m_k = 0, m_o = 0, m_w = 0, m_tidx = 0, m_ridx = 0;
    bit                   m_rv = 1'b0, m_done = 1'b0;
    logic signed [OW-1:0] m_peak = '0, m_rpeak = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_k = 0; m_o = 0; m_w = 0; m_tidx = 0; m_ridx = 0;
            m_rv = 0; m_done = 0; m_peak = '0; m_rpeak = '0;
        end else begin
            m_rv = 0;
            m_done = 0;
            if (!m_active) begin
                if (start && !abort) begin
                    m_active = 1; m_k = 0; m_o = 0; m_tidx = 0;
                end
            end else if (abort) begin
                m_active = 0; m_tidx = 0;
            end else begin
                if (m_o == S - 1) begin
                    m_peak = y;
                    m_w = (win_len == 0) ? DCW : int'(win_len);
                end else if (m_o >= S && m_o < S + m_w) begin
                    if (y > m_peak) m_peak = y;
                end
                m_o++;
                if (m_o == S + m_w) begin
                    m_rv = 1; m_rpeak = m_peak; m_ridx = m_k;
                end
                if (m_o == S + m_w + 3) begin
                    if (m_k == N - 1) begin
                        m_active = 0; m_done = 1; m_tidx = 0;
                    end else begin
                        m_k++; m_o = 0; m_tidx = m_k;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy", busy, m_active);
            check("drive_en", drive_en, m_active && (m_o < S + m_w + 1));
            check("test_idx", test_idx, m_tidx);
            check("result_valid", result_valid, m_rv);
            check("result_peak", $signed(result_peak), m_rpeak);
            check("result_idx", result_idx, m_ridx);
            check("done", done, m_done);
        end
    end

    int cyc = 0;
    int rv_cyc[$];
    int rv_idx[$];
    int done_cyc[$];
    int busy_cnt = 0;
    logic signed [OW-1:0] rv_peak[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (result_valid === 1'b1) begin
            rv_cyc.push_back(cyc);
            rv_peak.push_back($signed(result_peak));
            rv_idx.push_back(int'(result_idx));
        end
        if (done === 1'b1) done_cyc.push_back(cyc);
        if (busy === 1'b1) busy_cnt++;
    end

    function automatic int qi(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -9999;
    endfunction

    function automatic logic signed [OW-1:0] qp(input int i);
        return (i < rv_peak.size()) ? rv_peak[i] : '0;
    endfunction

    // y value sampled at the j-th edge after the start edge (edge 0)
    function automatic logic signed [OW-1:0] yval(input int mode, input int j);
        logic signed [OW-1:0] v;
        v = 40'sd5;
        if (mode == 5) v = 40'sd7;
        if (mode == 2) begin
            case (j)
                6: v = -40'sd8;    7: v = -40'sd3;   8: v = -40'sd1;
                9: v = -40'sd7;   10: v = -40'sd2;
                19: v = -40'sd5;  20: v = MAXP;
                21, 22, 23: v = '0;
                32: v = -40'sd100; 33: v = -40'sd40; 34: v = -40'sd90;
                35: v = -40'sd41;  36: v = -40'sd200;
                default: v = -40'sd50;
            endcase
        end
        return v;
    endfunction

    task automatic run_sweep(input int mode);
        bit fin;
        rv_cyc.delete(); rv_peak.delete(); rv_idx.delete(); done_cyc.delete();
        busy_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        y = yval(mode, 0);
        fin = 1'b0;
        for (int j = 1; j <= 200; j++) begin
            @(negedge clk);
            start = (mode == 6 && (j == 5 || j == 15));
            abort = (mode == 4 && j == 21);
            y = yval(mode, j);
            if (busy === 1'b0) begin
                fin = 1'b1;
                break;
            end
        end
        check("sweep_terminates", fin, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_three_results(input string tag, input int period,
                                       input int busy_exp);
        check({tag, "_nres"}, rv_cyc.size(), 3);
        check({tag, "_gap01"}, qi(rv_cyc, 1) - qi(rv_cyc, 0), period);
        check({tag, "_gap12"}, qi(rv_cyc, 2) - qi(rv_cyc, 1), period);
        check({tag, "_idx0"}, qi(rv_idx, 0), 0);
        check({tag, "_idx1"}, qi(rv_idx, 1), 1);
        check({tag, "_idx2"}, qi(rv_idx, 2), 2);
        check({tag, "_ndone"}, done_cyc.size(), 1);
        check({tag, "_done_lat"}, qi(done_cyc, 0) - qi(rv_cyc, 2), 3);
        check({tag, "_busy_cycles"}, busy_cnt, busy_exp);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_drive_en", drive_en, 0);
        check("rst_test_idx", test_idx, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_result_peak", result_peak, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);

        // constant y, win_len=4: 13-cycle period
        win_len = 16'd4;
        run_sweep(1);
        check_three_results("const", 13, 39);
        check("const_peak0", qp(0), 5);
        check("const_peak2", qp(2), 5);

        // signed peaks: all-negative window, max positive, least-negative
        run_sweep(2);
        check("neg_peak", qp(0), -1);
        check("maxpos_peak", qp(1), MAXP);
        check("allneg_peak", qp(2), -40);

        // win_len=0 selects DC window
        win_len = 16'd0;
        run_sweep(3);
        check_three_results("dc", 19, 57);
        win_len = 16'd4;

        // abort during MEASURE of test 1
        run_sweep(4);
        check("abort_nres", rv_cyc.size(), 1);
        check("abort_ndone", done_cyc.size(), 0);
        check("abort_busy_cycles", busy_cnt, 21);
        check("abort_drive_en", drive_en, 0);

        // start pulses while busy have no effect
        run_sweep(6);
        check_three_results("start_busy", 13, 39);

        // start and abort together while idle
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_abort_busy", busy, 0);
        check("start_abort_drive", drive_en, 0);
        @(negedge clk);
        check("start_abort_busy2", busy, 0);

        // async reset between edges mid-SETTLE
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_drive_en", drive_en, 0);
        check("arst_test_idx", test_idx, 0);
        check("arst_result_valid", result_valid, 0);
        check("arst_result_peak", result_peak, 0);
        check("arst_result_idx", result_idx, 0);
        check("arst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_sweep(5);
        check_three_results("post_rst", 13, 39);
        check("post_rst_peak", qp(0), 7);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
